// File: rtl/virtual_uart_host_drain.sv
// virtual_uart_host_drain: drains virtual UART TX bytes over AXI-lite into a byte FIFO
module virtual_uart_host_drain #(
  parameter int LOCAL_DATA_WIDTH = 32,
  parameter int LOCAL_ADDR_WIDTH = 32,
  parameter logic [LOCAL_ADDR_WIDTH-1:0] UART_BASE_ADDR = '0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          int_xdma_i,
  output logic [LOCAL_ADDR_WIDTH-1:0]   m_axilite_awaddr,
  output logic                          m_axilite_awvalid,
  input  logic                          m_axilite_awready,
  output logic [LOCAL_DATA_WIDTH-1:0]   m_axilite_wdata,
  output logic [LOCAL_DATA_WIDTH/8-1:0] m_axilite_wstrb,
  output logic                          m_axilite_wvalid,
  input  logic                          m_axilite_wready,
  input  logic [1:0]                    m_axilite_bresp,
  input  logic                          m_axilite_bvalid,
  output logic                          m_axilite_bready,
  output logic [LOCAL_ADDR_WIDTH-1:0]   m_axilite_araddr,
  output logic                          m_axilite_arvalid,
  input  logic                          m_axilite_arready,
  input  logic [LOCAL_DATA_WIDTH-1:0]   m_axilite_rdata,
  input  logic [1:0]                    m_axilite_rresp,
  input  logic                          m_axilite_rvalid,
  output logic                          m_axilite_rready,
  output logic [7:0]                    byte_data_o,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          err_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, HOLD} state_t;
  state_t state_q, state_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, err_q, err_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic r_hs, aw_hs, w_hs, b_hs, aw_ok, w_ok, push, pop;
  logic unused_rdata;
  assign r_hs = m_axilite_rvalid && rready_q;
  assign aw_hs = m_axilite_awready && awvalid_q;
  assign w_hs = m_axilite_wready && wvalid_q;
  assign b_hs = m_axilite_bvalid && bready_q;
  assign aw_ok = aw_done_q || aw_hs;
  assign w_ok = w_done_q || w_hs;
  assign push = r_hs && m_axilite_rresp == 2'b00;
  assign pop = byte_valid_o && byte_ready_i;
  assign unused_rdata = ^m_axilite_rdata;
  always_comb begin
    state_d = state_q;
    arvalid_d = arvalid_q && !m_axilite_arready;
    rready_d = rready_q && !m_axilite_rvalid;
    awvalid_d = awvalid_q && !m_axilite_awready;
    wvalid_d = wvalid_q && !m_axilite_wready;
    bready_d = bready_q && !m_axilite_bvalid;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    err_d = err_q || (r_hs && m_axilite_rresp != 2'b00) || (b_hs && m_axilite_bresp != 2'b00);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    case (state_q)
      // a full FIFO leaves the interrupt pending, which is the only backpressure
      IDLE: if (int_xdma_i && count_q < (PW+1)'(FIFO_DEPTH)) begin
        state_d = AR;
        arvalid_d = 1'b1;
      end
      AR: if (m_axilite_arready) begin
        state_d = R;
        rready_d = 1'b1;
      end
      R: if (m_axilite_rvalid) begin
        state_d = AW_W;
        awvalid_d = 1'b1;
        wvalid_d = 1'b1;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
      end
      AW_W: begin
        aw_done_d = aw_ok;
        w_done_d = w_ok;
        if (aw_ok && w_ok) begin
          state_d = B;
          bready_d = 1'b1;
        end
      end
      B: if (m_axilite_bvalid) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      err_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      err_q <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= m_axilite_rdata[7:0];
  end
  assign m_axilite_araddr = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(32'h04);
  assign m_axilite_awaddr = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(32'h10);
  assign m_axilite_wdata = '0;
  assign m_axilite_wstrb = '1;
  assign m_axilite_arvalid = arvalid_q;
  assign m_axilite_rready = rready_q;
  assign m_axilite_awvalid = awvalid_q;
  assign m_axilite_wvalid = wvalid_q;
  assign m_axilite_bready = bready_q;
  assign byte_data_o = mem_q[rd_ptr_q];
  assign byte_valid_o = count_q != '0;
  assign fifo_count_o = count_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_virtual_uart_host_drain.sv
// tb_virtual_uart_host_drain: virtual UART / AXI-lite slave model with a byte scoreboard
module tb_virtual_uart_host_drain;
  localparam logic [31:0] BASE = 32'h0000_1000;
  typedef struct packed {
    logic [7:0] data;
    int ar_lat;
    int aw_lat;
    int w_lat;
    logic [1:0] rresp;
    logic [1:0] bresp;
    logic exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic int_xdma;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [7:0] byte_data;
  logic byte_valid, byte_ready;
  logic [4:0] fifo_count;
  logic err;
  virtual_uart_host_drain #(
    .LOCAL_DATA_WIDTH(32), .LOCAL_ADDR_WIDTH(32), .UART_BASE_ADDR(BASE), .FIFO_DEPTH(16)
  ) dut (
    .clock_i(clk), .reset_i(rst), .int_xdma_i(int_xdma),
    .m_axilite_awaddr(awaddr), .m_axilite_awvalid(awvalid), .m_axilite_awready(awready),
    .m_axilite_wdata(wdata), .m_axilite_wstrb(wstrb), .m_axilite_wvalid(wvalid), .m_axilite_wready(wready),
    .m_axilite_bresp(bresp), .m_axilite_bvalid(bvalid), .m_axilite_bready(bready),
    .m_axilite_araddr(araddr), .m_axilite_arvalid(arvalid), .m_axilite_arready(arready),
    .m_axilite_rdata(rdata), .m_axilite_rresp(rresp), .m_axilite_rvalid(rvalid), .m_axilite_rready(rready),
    .byte_data_o(byte_data), .byte_valid_o(byte_valid), .byte_ready_i(byte_ready),
    .fifo_count_o(fifo_count), .err_o(err)
  );
  int n_chk = 0, n_fail = 0, n_pop = 0, rd_cnt = 0, wr_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int cfg_ar_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0;
  logic [1:0] cfg_rresp = 2'b00, cfg_bresp = 2'b00;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic wait_drain(input string name);
    int i = 0;
    while ((tx_q.size() != 0 || (byte_ready && exp_q.size() != 0)) && i < 600) begin
      @(negedge clk);
      i++;
    end
    chk(name, tx_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask
  // Slave responds after each edge from the DUT's registered outputs; the UART
  // interrupt stays high while a byte is pending and the ACK write retires it.
  initial begin : slave
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic r_pend = 0, aw_done = 0, w_done = 0, b_pend = 0;
    logic hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;
    logic [7:0] r_byte = 0;
    logic [1:0] r_cur = 0;
    {arready, rvalid, awready, wready, bvalid, int_xdma} = '0;
    rdata = '0; rresp = '0; bresp = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        {r_pend, aw_done, w_done, b_pend} = '0;
        {hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
        {arready, rvalid, awready, wready, bvalid, int_xdma} = '0;
        rresp = '0; bresp = '0;
      end else begin
        if (hs_ar) r_pend = 1'b1;
        if (hs_r) begin
          r_pend = 1'b0;
          rd_cnt++;
          if (r_cur == 2'b00) exp_q.push_back(r_byte);
        end
        if (hs_aw) aw_done = 1'b1;
        if (hs_w) begin
          w_done = 1'b1;
          if (tx_q.size() != 0) void'(tx_q.pop_front());
        end
        if (hs_b) begin
          b_pend = 1'b0;
          wr_cnt++;
        end
        if (aw_done && w_done) begin
          aw_done = 1'b0; w_done = 1'b0; b_pend = 1'b1;
        end
        arready = arvalid && ar_cnt >= cfg_ar_lat;
        ar_cnt = (arvalid && !arready) ? ar_cnt + 1 : 0;
        awready = awvalid && aw_cnt >= cfg_aw_lat;
        aw_cnt = (awvalid && !awready) ? aw_cnt + 1 : 0;
        wready = wvalid && w_cnt >= cfg_w_lat;
        w_cnt = (wvalid && !wready) ? w_cnt + 1 : 0;
        r_byte = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        r_cur = r_pend ? cfg_rresp : 2'b00;
        rvalid = r_pend;
        rdata = {24'hC3A55A, r_byte};
        rresp = r_cur;
        bvalid = b_pend;
        bresp = b_pend ? cfg_bresp : 2'b00;
        int_xdma = tx_q.size() != 0;
        hs_ar = arvalid && arready;
        hs_r = rvalid && rready;
        hs_aw = awvalid && awready;
        hs_w = wvalid && wready;
        hs_b = bvalid && bready;
        if (hs_ar) chk("araddr", araddr, BASE + 32'h04);
        if (hs_aw) chk("awaddr", awaddr, BASE + 32'h10);
        if (hs_w) begin
          chk("wdata", wdata, 32'h0);
          chk("wstrb", {28'h0, wstrb}, 32'hF);
        end
      end
    end
  end
  initial begin : consumer
    forever begin
      @(negedge clk); #2;
      if (!rst && byte_valid && byte_ready) begin
        n_pop++;
        chk("byte expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("byte data", byte_data, exp_q.pop_front());
      end
    end
  end
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin : main
    vec_t v[9];
    int base_rd, base_wr, base_pop, seen, t;
    v[0] = '{8'h41, 0, 0, 0, 2'b00, 2'b00, 1'b0};
    v[1] = '{8'hA5, 2, 0, 0, 2'b00, 2'b00, 1'b0};
    v[2] = '{8'h00, 0, 1, 1, 2'b00, 2'b00, 1'b0};
    v[3] = '{8'hFF, 1, 2, 0, 2'b00, 2'b00, 1'b0};
    v[4] = '{8'h3C, 0, 0, 2, 2'b00, 2'b00, 1'b0};
    v[5] = '{8'h7E, 3, 1, 3, 2'b00, 2'b00, 1'b0};
    v[6] = '{8'h55, 0, 0, 0, 2'b10, 2'b00, 1'b1};
    v[7] = '{8'h66, 0, 0, 0, 2'b00, 2'b11, 1'b1};
    v[8] = '{8'h99, 1, 1, 1, 2'b00, 2'b00, 1'b1};
    byte_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset arvalid", arvalid, 0);
    chk("reset rready", rready, 0);
    chk("reset awvalid", awvalid, 0);
    chk("reset wvalid", wvalid, 0);
    chk("reset bready", bready, 0);
    chk("reset byte_valid", byte_valid, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset err", err, 0);
    rst = 1'b0;
    // single byte: AR one cycle after the interrupt is sampled, byte shown for one cycle
    base_rd = rd_cnt; base_wr = wr_cnt;
    byte_ready = 1'b1;
    tx_q.push_back(8'h41);
    @(negedge clk);
    chk("single arvalid before sample", arvalid, 0);
    @(negedge clk);
    chk("single arvalid after sample", arvalid, 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (byte_valid) seen++;
    end
    chk("single byte_valid cycles", seen, 1);
    chk("single reads", rd_cnt - base_rd, 1);
    chk("single writes", wr_cnt - base_wr, 1);
    chk("single int cleared", int_xdma, 0);
    chk("single err", err, 0);
    chk("single scoreboard", exp_q.size(), 0);
    for (int i = 0; i < 9; i++) begin
      cfg_ar_lat = v[i].ar_lat; cfg_aw_lat = v[i].aw_lat; cfg_w_lat = v[i].w_lat;
      cfg_rresp = v[i].rresp; cfg_bresp = v[i].bresp;
      base_rd = rd_cnt; base_wr = wr_cnt; base_pop = n_pop;
      tx_q.push_back(v[i].data);
      wait_drain("vec drain");
      chk("vec err", err, v[i].exp_err);
      chk("vec reads", rd_cnt - base_rd, 1);
      chk("vec ack writes", wr_cnt - base_wr, 1);
      chk("vec bytes out", n_pop - base_pop, (v[i].rresp == 2'b00) ? 1 : 0);
      chk("vec fifo empty", fifo_count, 0);
    end
    cfg_ar_lat = 0; cfg_aw_lat = 0; cfg_w_lat = 0; cfg_rresp = 2'b00; cfg_bresp = 2'b00;
    repeat (20) @(negedge clk);
    chk("err sticky", err, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("err cleared by reset", err, 0);
    rst = 1'b0;
    // split write handshake: AW taken at k, W at k+3
    cfg_w_lat = 3;
    tx_q.push_back(8'h5A);
    t = 0;
    while (!awvalid && t < 50) begin @(negedge clk); t++; end
    chk("split awvalid raised", awvalid, 1);
    chk("split wvalid raised together", wvalid, 1);
    @(negedge clk);
    chk("split k+1 awvalid", awvalid, 0);
    chk("split k+1 wvalid", wvalid, 1);
    chk("split k+1 bready", bready, 0);
    @(negedge clk);
    chk("split k+2 wvalid", wvalid, 1);
    chk("split k+2 bready", bready, 0);
    @(negedge clk);
    chk("split k+3 wvalid", wvalid, 1);
    chk("split k+3 bready", bready, 0);
    @(negedge clk);
    chk("split k+4 wvalid", wvalid, 0);
    chk("split k+4 bready", bready, 1);
    wait_drain("split drain");
    cfg_w_lat = 0;
    // burst of 20 into a 16-deep FIFO with the consumer stalled
    byte_ready = 1'b0;
    base_pop = n_pop;
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i));
    t = 0;
    while (fifo_count != 5'd16 && t < 1000) begin @(negedge clk); t++; end
    chk("burst fill", fifo_count, 16);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (arvalid) seen++;
    end
    chk("burst no AR while full", seen, 0);
    chk("burst count held", fifo_count, 16);
    chk("burst int pending", int_xdma, 1);
    chk("burst bytes left in UART", tx_q.size(), 4);
    byte_ready = 1'b1;
    wait_drain("burst drain");
    chk("burst scoreboard", exp_q.size(), 0);
    chk("burst bytes out", n_pop - base_pop, 20);
    chk("burst fifo empty", fifo_count, 0);
    // reset while the ACK write is outstanding with 3 bytes queued
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) tx_q.push_back(8'hE0 + 8'(i));
    wait_drain("rst prefill drain");
    chk("rst prefill count", fifo_count, 3);
    cfg_w_lat = 6;
    tx_q.push_back(8'hE3);
    t = 0;
    while (!awvalid && t < 100) begin @(negedge clk); t++; end
    chk("rst reached AW_W", awvalid, 1);
    rst = 1'b1;
    tx_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst arvalid", arvalid, 0);
    chk("rst rready", rready, 0);
    chk("rst awvalid", awvalid, 0);
    chk("rst wvalid", wvalid, 0);
    chk("rst bready", bready, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst byte_valid", byte_valid, 0);
    chk("rst err", err, 0);
    rst = 1'b0;
    cfg_w_lat = 0;
    byte_ready = 1'b1;
    tx_q.push_back(8'h77);
    @(negedge clk);
    chk("post-rst arvalid before sample", arvalid, 0);
    @(negedge clk);
    chk("post-rst arvalid after sample", arvalid, 1);
    wait_drain("post-rst drain");
    // move the pointers near the end so the next five bytes wrap
    for (int i = 0; i < 14; i++) tx_q.push_back(8'h80 + 8'(i));
    wait_drain("wrap pre drain");
    chk("wrap pre scoreboard", exp_q.size(), 0);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) tx_q.push_back(8'hC0 + 8'(i));
    wait_drain("wrap fill drain");
    chk("wrap count 5", fifo_count, 5);
    tx_q.push_back(8'hC5);
    t = 0;
    while (!(rvalid && rready) && t < 100) begin @(negedge clk); t++; end
    chk("wrap push cycle", rvalid && rready, 1);
    byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
    chk("push+pop count", fifo_count, 5);
    byte_ready = 1'b1;
    wait_drain("wrap final drain");
    chk("wrap scoreboard", exp_q.size(), 0);
    chk("wrap fifo empty", fifo_count, 0);
    chk("final err", err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
